i2s_transmitter: RTL

Synthesizable I2S master transmitter. It accepts stereo 24-bit sample pairs through a valid/ready handshake, generates bck and lrck from the system clock, and serializes the samples in standard I2S format. The bit and frame timing matches the team's I2S receiver bench model: MSB first, one-bck delay after each lrck edge, and lrck low selects left. It sits between the sample FIFO output and the DAC serial port.

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_clock_gen.sv | 56 +++++
 rtl/i2s_transmitter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared defaults and types for the I2S transmitter slice.
package i2s_pkg;

  localparam int SAMPLE_WIDTH = 24;
  localparam int SLOT_BITS    = 32;
  localparam int BCK_HALF     = 2;
  localparam int BIT_CNT_W    = $clog2(2 * SLOT_BITS);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } i2s_frame_t;

  // Slot positions 1..width carry sample bits; position 0 is the one-bck delay.
  function automatic logic slot_is_data(input int b, input int width);
    return (b >= 1) && (b <= width);
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit-clock divider and frame counter: produces bck, lrck and the fall tick that paces the serializer.
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = i2s_pkg::SLOT_BITS,
  parameter int BCK_HALF  = i2s_pkg::BCK_HALF,
  parameter int CNT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             bck,
  output logic             lrck,
  output logic             fall_tick,
  output logic             frame_start,
  output logic [CNT_W-1:0] bit_cnt_next
);

  localparam int DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_reg;
  logic             bck_reg;
  logic             lrck_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             div_wrap;

  assign div_wrap     = (div_reg == DIV_LAST);
  assign fall_tick    = div_wrap && bck_reg;
  assign frame_start  = fall_tick && (bit_cnt_reg == CNT_LAST);
  assign bit_cnt_next = (bit_cnt_reg == CNT_LAST) ? '0 : bit_cnt_reg + 1'b1;

  // Counter starts on the last bit so the first fall tick opens a fresh frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg     <= '0;
      bck_reg     <= 1'b0;
      lrck_reg    <= 1'b1;
      bit_cnt_reg <= CNT_LAST;
    end else begin
      div_reg <= div_wrap ? '0 : div_reg + 1'b1;
      if (div_wrap) begin
        bck_reg <= ~bck_reg;
      end
      if (fall_tick) begin
        bit_cnt_reg <= bit_cnt_next;
        lrck_reg    <= (bit_cnt_next >= SLOT_C);
      end
    end
  end

  assign bck  = bck_reg;
  assign lrck = lrck_reg;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: valid/ready sample intake, one-deep holding register, MSB-first serializer.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = i2s_pkg::SAMPLE_WIDTH,
  parameter int SLOT_BITS    = i2s_pkg::SLOT_BITS,
  parameter int BCK_HALF     = i2s_pkg::BCK_HALF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [2*SAMPLE_WIDTH-1:0] sample_data,
  output logic                      bck,
  output logic                      lrck,
  output logic                      sdata,
  output logic                      underrun
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam logic [CNT_W-1:0] SLOT_C = CNT_W'(SLOT_BITS);

  logic             fall_tick;
  logic             frame_start;
  logic [CNT_W-1:0] bit_cnt_next;

  i2s_clock_gen #(
    .SLOT_BITS (SLOT_BITS),
    .BCK_HALF  (BCK_HALF),
    .CNT_W     (CNT_W)
  ) u_clock_gen (
    .clk          (clk),
    .reset        (reset),
    .bck          (bck),
    .lrck         (lrck),
    .fall_tick    (fall_tick),
    .frame_start  (frame_start),
    .bit_cnt_next (bit_cnt_next)
  );

  logic [2*SAMPLE_WIDTH-1:0] holding_reg, holding_next;
  logic                      holding_full_reg, holding_full_next;
  logic                      sample_ready_reg, sample_ready_next;
  logic [SAMPLE_WIDTH-1:0]   shift_l_reg, shift_l_next;
  logic [SAMPLE_WIDTH-1:0]   shift_r_reg, shift_r_next;
  logic                      sdata_reg, sdata_next;
  logic                      underrun_reg, underrun_next;

  logic             accept;
  logic             in_right;
  logic [CNT_W-1:0] slot_pos;

  assign accept   = sample_valid && sample_ready_reg;
  assign in_right = (bit_cnt_next >= SLOT_C);
  assign slot_pos = in_right ? (bit_cnt_next - SLOT_C) : bit_cnt_next;

  always_comb begin
    holding_next      = holding_reg;
    holding_full_next = holding_full_reg;
    shift_l_next      = shift_l_reg;
    shift_r_next      = shift_r_reg;
    sdata_next        = sdata_reg;
    underrun_next     = 1'b0;

    // Accept only happens while holding is empty, so it never collides with the frame-start unload.
    if (accept) begin
      holding_next      = sample_data;
      holding_full_next = 1'b1;
    end

    if (fall_tick) begin
      sdata_next = 1'b0;
      if (frame_start) begin
        underrun_next = ~holding_full_reg;
        if (holding_full_reg) begin
          shift_l_next      = holding_reg[2*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
          shift_r_next      = holding_reg[SAMPLE_WIDTH-1:0];
          holding_full_next = 1'b0;
        end else begin
          shift_l_next = '0;
          shift_r_next = '0;
        end
      end else if (slot_is_data(int'(slot_pos), SAMPLE_WIDTH)) begin
        if (in_right) begin
          sdata_next   = shift_r_reg[SAMPLE_WIDTH-1];
          shift_r_next = shift_r_reg << 1;
        end else begin
          sdata_next   = shift_l_reg[SAMPLE_WIDTH-1];
          shift_l_next = shift_l_reg << 1;
        end
      end
    end

    sample_ready_next = ~holding_full_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holding_reg      <= '0;
      holding_full_reg <= 1'b0;
      sample_ready_reg <= 1'b1;
      shift_l_reg      <= '0;
      shift_r_reg      <= '0;
      sdata_reg        <= 1'b0;
      underrun_reg     <= 1'b0;
    end else begin
      holding_reg      <= holding_next;
      holding_full_reg <= holding_full_next;
      sample_ready_reg <= sample_ready_next;
      shift_l_reg      <= shift_l_next;
      shift_r_reg      <= shift_r_next;
      sdata_reg        <= sdata_next;
      underrun_reg     <= underrun_next;
    end
  end

  assign sample_ready = sample_ready_reg;
  assign sdata        = sdata_reg;
  assign underrun     = underrun_reg;

endmodule
